// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: pc, one-deep memory pipeline, 2-entry output buffer.
// Optional fetch_count performance counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_controller #(
    parameter int ADDR_W    = 12,
    parameter int INSTR_W   = 12,
    parameter int MEM_DEPTH = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               busy,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        fetch_count,
`endif
    output logic               fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(MEM_DEPTH);

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0]  pc_q;
    logic               inflight_q;
    logic [ADDR_W-1:0]  inflight_pc_q;

    logic [INSTR_W-1:0] fifo_instr [2];
    logic [ADDR_W-1:0]  fifo_pc    [2];
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q;

    logic               pop;
    logic               push;
    logic               flush;
    logic               issue;
    logic               pc_ok;
    logic               redir_ok;
    logic [2:0]         pending;

    // Handshake and pipeline bookkeeping shared by the FSM and datapath.
    // pending counts slots that will be occupied after this cycle's pop.
    assign instr_valid = (count_q != 2'd0);
    assign pop         = instr_valid & instr_ready;
    assign pc_ok       = (pc_q < DEPTH_LIM);
    assign redir_ok    = (redirect_pc < DEPTH_LIM);
    assign flush       = redirect_valid && (state_q != S_IDLE);
    assign push        = inflight_q && !flush;
    assign pending     = {2'b00, inflight_q} + {1'b0, count_q}
                       - {2'b00, pop};

    assign imem_addr = pc_q;
    assign instr_out = instr_valid ? fifo_instr[rd_ptr_q] : '0;
    assign pc_out    = instr_valid ? fifo_pc[rd_ptr_q]    : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks the range check in RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (!redirect_valid && !pc_ok) begin
                    state_d = S_FAULT;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_FAULT: begin
                if (redirect_valid && redir_ok) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state: issue gate, busy and the sticky fault flag.
    always_comb begin
        issue = 1'b0;
        busy  = inflight_q || (count_q != 2'd0);
        fault = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_RUN: begin
                busy  = 1'b1;
                issue = pc_ok && !redirect_valid && (pending < 3'd2);
            end
            S_HALT: begin
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Program counter and the single outstanding memory read.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end else if (issue) begin
                pc_q <= pc_q + 1'b1;
            end
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    // Output buffer pointers and occupancy; a flush empties it.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            assert (!(push && !pop && count_q == 2'd2));
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Buffer storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= imem_rdata;
            fifo_pc[wr_ptr_q]    <= inflight_pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating count of accepted handshakes; survives redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 16'd0;
        end else if (pop && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the 12-bit instruction memory, which returns registered read data one cycle after the address is presented.
- Holds the program counter and issues one fetch per cycle at full rate.
- Delivers {pc, instruction} pairs to decode over a valid/ready handshake, using a 2-entry output buffer to absorb backpressure.
- Handles start, halt, branch redirect (flush) and out-of-range fetch faults.

Parameters:
- ADDR_W, 12, width of pc and memory address
- INSTR_W, 12, instruction width
- MEM_DEPTH, 24, number of valid instruction words; addresses >= MEM_DEPTH fault
- RESET_PC, 0, pc value after reset

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; IDLE/HALT -> RUN
- halt_req  in  1  pulse; RUN -> HALT
- redirect_valid  in  1  branch/jump redirect, single-cycle
- redirect_pc  in  ADDR_W  redirect target
- imem_addr  out  ADDR_W  memory read address, combinational from pc register
- imem_rdata  in  INSTR_W  memory read data, valid the cycle after issue
- instr_valid  out  1  head of output buffer valid
- instr_ready  in  1  decode accepts head
- instr_out  out  INSTR_W  head instruction
- pc_out  out  ADDR_W  head pc
- busy  out  1  state==RUN or in-flight or buffer non-empty
- fault  out  1  sticky out-of-range flag

Behaviour:
- Clocking/reset: one clock `clk`; reset is synchronous and active-high (`reset`).
- Reset values: state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, inflight=0, buffer empty, instr_valid=0, instr_out=0, pc_out=0, busy=0, fault=0.
- States:
  - IDLE: start -> RUN.
  - RUN: halt_req -> HALT; pc >= MEM_DEPTH at issue time -> FAULT.
  - HALT: start -> RUN.
  - FAULT: redirect_valid with redirect_pc < MEM_DEPTH -> RUN and clears fault; start is ignored.
- Issue:
  - Condition: state==RUN, pc < MEM_DEPTH, no redirect this cycle, and (inflight + count - pop) < 2, where pop = instr_valid & instr_ready.
  - On issue: imem_addr=pc; at the clock edge, inflight<=1, inflight_pc<=pc, pc<=pc+1 (ADDR_W wrap, unreachable in practice).
- Return: if inflight=1, imem_rdata and inflight_pc are pushed into the buffer at the next edge. Inflight clears unless a new issue occurs in the same cycle.
- Latency: issue in cycle N -> instr_valid in cycle N+2 (empty buffer). Sustained throughput is 1 instr/cycle while instr_ready=1.
- Buffer: 2-entry FIFO. Push and pop in the same cycle are allowed at any occupancy. Overflow is impossible by the issue rule; this is verified by assertion.
- Handshake: instr_out and pc_out stay stable while instr_valid=1 and instr_ready=0.
- Redirect:
  - Highest priority in RUN/HALT/FAULT.
  - Flushes the buffer, clears inflight (the returning data next cycle is discarded), sets pc<=redirect_pc, and suppresses issue that cycle.
  - instr_valid=0 the cycle after.
  - In IDLE only pc is updated.
- Simultaneous events:
  - redirect + halt_req: both take effect (flush, pc update, state HALT).
  - start + halt_req in HALT: start wins.
- Halt: issue stops immediately. In-flight data still lands; the buffer keeps draining. busy drops once the buffer is empty.
- Fault:
  - No issue when pc >= MEM_DEPTH; the memory is never addressed out of range.
  - fault goes to 1 at the next edge.
  - Already-buffered instructions still drain.
- imem_addr = pc at all times; the memory output is ignored unless inflight=1.
- Reset mid-operation: all state returns to reset values at that edge; in-flight data is dropped.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output `fetch_count` (16 bits, reset 0).
  - Increments on each accepted handshake (instr_valid & instr_ready).
  - Saturates at 16'hFFFF.
  - Not cleared by redirect.
- Undefined: the port and counter do not exist.

Test Plan:
- Reset, memory preloaded 0..23 with 12'h100+k, start, instr_ready=1 -> first instr_valid 2 cycles after issue; pc_out 0,1,2..., instr_out 12'h100.. back-to-back, one per cycle.
- Backpressure: ready low for 5 cycles mid-stream -> buffer fills to 2, issue stalls, head held stable; on release, sequence continues with no gaps or duplicates.
- Redirect to pc 10 while buffer holds pc 3,4 and pc 5 is in flight -> 3, 4, 5 never delivered; next delivered pc_out=10, instr 12'h10A.
- Run to the end of memory -> pc 23 delivered, fault=1, no imem_addr >= 24 issued with inflight; redirect to 0 clears fault and resumes.
- halt_req at pc 7 issue -> in-flight/buffered entries drain, busy falls; start -> resumes at the next pc with no loss.
- With FETCH_PERF_CNT_EN: 20 accepted fetches with 3 stall cycles and one redirect -> fetch_count=20.
